tt_uart_tx: RTL and testbench
=============================

# tt_uart_tx

Serial transmitter that takes bytes from the design's parallel side and sends them as 8N1 asynchronous serial frames on a single output line. It sits at the output end of a Tiny Tapeout top level: user logic pushes bytes through a valid/ready handshake into a small FIFO, and the transmitter drives one dedicated output pin. It is the outbound counterpart to the input-side byte-capture logic already in the top.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Legal values are 2 to 65535.
- `FIFO_DEPTH`, default 4: number of byte entries. Must be a power of two, 2 to 16.
- `clk`, input, 1: the single clock. All state changes on its rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `data_in`, input, 8: byte to transmit.
- `data_valid`, input, 1: `data_in` is valid this cycle.
- `data_ready`, output, 1: the FIFO can accept a byte. Equals `count < FIFO_DEPTH`.
- `tx`, output, 1: registered serial line. Idles high.
- `busy`, output, 1: a frame is in progress (state is not IDLE).
- `fifo_count`, output, $clog2(FIFO_DEPTH)+1: number of queued bytes, not counting the byte currently being shifted.

## Operation
- **Reset values:** `tx`=1, `busy`=0, `fifo_count`=0, `data_ready`=1, state=IDLE, all counters 0. Asserting `reset` mid-frame aborts the frame: `tx` returns high asynchronously and queued bytes are discarded.
- **Push:** occurs on a rising edge when `data_valid && data_ready`. The byte is written at the write pointer and the count increments. If `data_valid` is high while the FIFO is full, the byte is ignored and no state changes.
- **Pop:** occurs when the FSM loads the shift register. The read pointer advances and the count decrements.
- **Simultaneous push and pop:** the count is unchanged and both pointers advance. When the FIFO is full, `data_ready` is 0 even if a pop occurs in the same cycle, so no push is possible that cycle.
- **Pointer wrap:** pointers wrap modulo FIFO_DEPTH.
- **FSM states:** IDLE, START, DATA, STOP.
  - **IDLE:** if count is nonzero, pop into the 8-bit shift register, set `tx`=0, clear the bit timer, and go to START. Otherwise hold `tx`=1.
  - **START:** hold `tx`=0 for CLKS_PER_BIT cycles. Then set `tx`=shift[0], set the bit index to 0, and go to DATA.
  - **DATA:** each bit is held for CLKS_PER_BIT cycles. At the end of each bit period, shift right and increment the bit index. After bit 7's period, set `tx`=1 and go to STOP. Bits are sent LSB first.
  - **STOP:** hold `tx`=1 for CLKS_PER_BIT cycles. At the end of the period:
    - if count is nonzero, pop, set `tx`=0 and go to START (back-to-back frames, no idle gap);
    - otherwise go to IDLE.
- **Bit timer:** counts 0 to CLKS_PER_BIT-1. It is $clog2(CLKS_PER_BIT) bits wide, with a minimum of 1 bit.
- **Data capture:** the byte is captured at pop. `data_in` changes after acceptance do not affect the frame.

## Timing
- **Latency:** a byte pushed on edge N into an empty FIFO while IDLE is popped on edge N+1. `tx` falls on edge N+1. `busy` rises on edge N+1.
- **Frame length:** exactly 10×CLKS_PER_BIT cycles, from the `tx` falling edge to the end of the stop bit.
- **Consecutive frames:** the next start bit begins on the same edge the previous stop bit ends, giving a period of exactly 10×CLKS_PER_BIT cycles.
- **busy deassertion:** `busy` falls on the edge where STOP ends with an empty FIFO. It is low for at least one cycle before the next frame can start from IDLE.
- **fifo_count:** reflects the push and pop of edge N in the cycle after edge N. `data_ready` is combinational from the count.
- **Outputs:** no combinational path from any input to `tx` or `busy`.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle. Require `tx`=1, `busy`=0, `fifo_count`=0, `data_ready`=1 immediately, with no clock edge needed.
- **Single byte, CLKS_PER_BIT=4:** push 0xA5 on edge 10. Require:
  - `tx` falls on edge 11;
  - `tx` sequence per 4-cycle slot is 0,1,0,1,0,0,1,0,1,1;
  - `busy` falls on edge 51.
- **Back-to-back:** push 0x00 then 0xFF on consecutive cycles. Require two frames with no idle cycle between the stop of frame 1 and the start of frame 2, and a total of 80 cycles of `busy` at CLKS_PER_BIT=4.
- **FIFO full, FIFO_DEPTH=4:** hold `data_valid` high with bytes 0x01 to 0x06 while a frame is active.
  - `data_ready` falls when `fifo_count`=4.
  - Byte 0x06 is rejected while full.
  - Transmitted order is 0x01, 0x02, 0x03, 0x04, 0x05.
  - Check the push on the pop edge: no push while full, even on the edge where the count drops.
- **Reset mid-frame:** assert `reset` during DATA bit 3 of 0x3C with 2 bytes queued. Require `tx`=1 at once and `fifo_count`=0. After release, require no further frames without new pushes.
- **Minimum divisor, CLKS_PER_BIT=2:** send 0x80. Require each bit held exactly 2 cycles, the MSB high in slot 8, and a frame length of 20 cycles.

Source files
------------

// File: rtl/tt_uart_tx_if.sv
// tt_uart_tx_if: byte handshake between user logic and the UART transmitter FIFO.
//   data_in    : byte offered for transmission
//   data_valid : data_in is valid this cycle
//   data_ready : transmitter FIFO can accept a byte this cycle
// master = byte producer, slave = tt_uart_tx.
interface tt_uart_tx_if;

    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready
    );

endinterface

// File: rtl/tt_uart_tx.sv
// tt_uart_tx: 8N1 asynchronous serial transmitter fed by a small byte FIFO.
//   clk        : single clock, rising edge
//   reset      : asynchronous, active-high
//   bus        : slave side of the byte handshake (data_in/data_valid/data_ready)
//   tx         : registered serial line, idles high
//   busy       : registered, high while a frame is in progress
//   fifo_count : queued bytes, excluding the byte being shifted
module tt_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    tt_uart_tx_if.slave                   bus,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // FIFO storage and pointers
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          ready;
    logic          push;
    logic          pop;
    logic          fifo_nonempty;

    // Transmit state
    state_t        state_q;
    state_t        state_d;
    logic [7:0]    shift_q;
    logic [7:0]    shift_d;
    logic [2:0]    bit_q;
    logic [2:0]    bit_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic          tx_d;
    logic          busy_d;
    logic          timer_end;

    // Ready depends only on the registered count, so no push can sneak in
    // on the edge where a full FIFO is popped.
    assign ready          = (count_q < COUNT_FULL);
    assign bus.data_ready = ready;
    assign push           = bus.data_valid && ready;
    assign fifo_nonempty  = (count_q != '0);
    assign timer_end      = (timer_q == TIMER_LAST);
    assign fifo_count     = count_q;

    // FIFO byte storage; contents need no reset because count gates reads
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.data_in;
        end
    end

    // FIFO occupancy update
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers and count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    // Transmit FSM state register and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            timer_q <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            timer_q <= timer_d;
            tx      <= tx_d;
            busy    <= busy_d;
        end
    end

    // Transmit FSM next-state and output logic
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        timer_d = timer_q;
        tx_d    = tx;
        pop     = 1'b0;

        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr_q];
                    tx_d    = 1'b0;
                    timer_d = '0;
                    state_d = START;
                end
            end

            START: begin
                if (timer_end) begin
                    timer_d = '0;
                    tx_d    = shift_q[0];
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            DATA: begin
                if (timer_end) begin
                    timer_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        // Next bit is shift[1] before the shift takes effect
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            STOP: begin
                if (timer_end) begin
                    timer_d = '0;
                    if (fifo_nonempty) begin
                        // Back-to-back: start bit begins as stop bit ends
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr_q];
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                timer_d = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_tt_uart_tx.sv
// tb_tt_uart_tx: self-checking bench for tt_uart_tx.
// Two instances: CLKS_PER_BIT=4 (main tests) and CLKS_PER_BIT=2 (minimum divisor).
// Accepted bytes are queued as expected frames; a line monitor per instance
// decodes each frame from tx and compares it with the queue head.
module tb_tt_uart_tx;

    logic       clk;
    logic       reset;
    logic       tx4;
    logic       busy4;
    logic [2:0] cnt4;
    logic       tx2;
    logic       busy2;
    logic [2:0] cnt2;

    int checks;
    int errors;
    int cyc;

    logic [7:0] sb4[$];
    logic [7:0] sb2[$];
    int         starts4[$];

    tt_uart_tx_if bus4();
    tt_uart_tx_if bus2();

    tt_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) u_dut4 (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus4),
        .tx         (tx4),
        .busy       (busy4),
        .fifo_count (cnt4)
    );

    tt_uart_tx #(.CLKS_PER_BIT(2), .FIFO_DEPTH(4)) u_dut2 (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus2),
        .tx         (tx2),
        .busy       (busy2),
        .fifo_count (cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic get_tx(input int w);
        return (w == 0) ? tx4 : tx2;
    endfunction

    // Decode one frame per start bit; each slot must hold its level for
    // exactly CLKS_PER_BIT samples. A reset mid-frame abandons the frame.
    task automatic monitor(input int w);
        int         n_cpb;
        int         start_cyc;
        int         sb_size;
        logic       v;
        logic       slot_v;
        logic       stable;
        logic       aborted;
        logic [9:0] slots;
        logic [7:0] exp;
        n_cpb = (w == 0) ? 4 : 2;
        forever begin
            @(negedge clk);
            if (!reset && get_tx(w) === 1'b0) begin
                start_cyc = cyc;
                aborted   = 1'b0;
                stable    = 1'b1;
                slots     = '0;
                slot_v    = 1'b0;
                for (int s = 0; s < 10; s++) begin
                    for (int c = 0; c < n_cpb; c++) begin
                        if (!(s == 0 && c == 0)) @(negedge clk);
                        if (reset) begin
                            aborted = 1'b1;
                            break;
                        end
                        v = get_tx(w);
                        if (c == 0) begin
                            slot_v   = v;
                            slots[s] = v;
                        end else if (v !== slot_v) begin
                            stable = 1'b0;
                        end
                    end
                    if (aborted) break;
                end
                if (!aborted) begin
                    if (w == 0) starts4.push_back(start_cyc);
                    sb_size = (w == 0) ? sb4.size() : sb2.size();
                    check("frame_expected", 32'(sb_size != 0), 32'(1));
                    if (sb_size != 0) begin
                        exp = (w == 0) ? sb4.pop_front() : sb2.pop_front();
                        check("frame_byte", 32'(slots[8:1]), 32'(exp));
                    end
                    check("frame_start_bit", 32'(slots[0]), 32'(0));
                    check("frame_stop_bit", 32'(slots[9]), 32'(1));
                    check("frame_bit_stable", 32'(stable), 32'(1));
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    // Offer one byte for one edge; expect it only if ready before that edge
    task automatic drive4(input logic [7:0] b);
        @(negedge clk);
        bus4.data_in    = b;
        bus4.data_valid = 1'b1;
        if (bus4.data_ready) sb4.push_back(b);
        @(posedge clk);
        #1;
        bus4.data_valid = 1'b0;
    endtask

    task automatic drive2(input logic [7:0] b);
        @(negedge clk);
        bus2.data_in    = b;
        bus2.data_valid = 1'b1;
        if (bus2.data_ready) sb2.push_back(b);
        @(posedge clk);
        #1;
        bus2.data_valid = 1'b0;
    endtask

    task automatic wait_idle4(input string tag);
        int n;
        n = 0;
        while ((busy4 || cnt4 != 3'd0) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 32'(busy4 || cnt4 != 3'd0), 32'(0));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int         n;
        int         k;
        logic       busy_ok;
        logic [7:0] exp_byte;
        logic [19:0] wave;
        logic [19:0] wave_exp;

        checks          = 0;
        errors          = 0;
        bus4.data_in    = '0;
        bus4.data_valid = 1'b0;
        bus2.data_in    = '0;
        bus2.data_valid = 1'b0;
        reset           = 1'b1;

        // Reset values
        @(negedge clk);
        check("rst_tx", 32'(tx4), 32'(1));
        check("rst_busy", 32'(busy4), 32'(0));
        check("rst_count", 32'(cnt4), 32'(0));
        check("rst_ready", 32'(bus4.data_ready), 32'(1));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Asynchronous reset during a start bit with bytes queued
        drive4(8'h5A);
        drive4(8'h6B);
        drive4(8'h7C);
        check("arst_pre_tx", 32'(tx4), 32'(0));
        check("arst_pre_count", 32'(cnt4), 32'(2));
        #1;
        reset = 1'b1;
        #1;
        check("arst_tx", 32'(tx4), 32'(1));
        check("arst_busy", 32'(busy4), 32'(0));
        check("arst_count", 32'(cnt4), 32'(0));
        check("arst_ready", 32'(bus4.data_ready), 32'(1));
        sb4.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte: tx falls one edge after push, busy lasts 40 cycles
        drive4(8'hA5);
        check("single_tx_hold", 32'(tx4), 32'(1));
        check("single_count", 32'(cnt4), 32'(1));
        @(posedge clk);
        #1;
        check("single_tx_fall", 32'(tx4), 32'(0));
        check("single_busy_rise", 32'(busy4), 32'(1));
        check("single_popped", 32'(cnt4), 32'(0));
        n = 1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (!busy4) break;
            n++;
        end
        check("single_busy_cycles", 32'(n), 32'(40));
        repeat (2) @(negedge clk);
        check("single_sb_empty", 32'(sb4.size()), 32'(0));

        // Back-to-back: 0x00 then 0xFF, 80 contiguous busy cycles
        k = starts4.size();
        n = 0;
        drive4(8'h00);
        if (busy4) n++;
        drive4(8'hFF);
        if (busy4) n++;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (busy4) n++;
            else break;
        end
        check("b2b_busy_cycles", 32'(n), 32'(80));
        repeat (2) @(negedge clk);
        check("b2b_frames", 32'(starts4.size() - k), 32'(2));
        if (starts4.size() - k == 2) begin
            check("b2b_start_gap", 32'(starts4[k+1] - starts4[k]), 32'(40));
        end
        check("b2b_sb_empty", 32'(sb4.size()), 32'(0));
        wait_idle4("b2b_idle");

        // FIFO full: 0x01..0x05 accepted, 0x06 refused even on the pop edge
        for (int b = 1; b <= 5; b++) begin
            drive4(8'(b));
        end
        check("full_count", 32'(cnt4), 32'(4));
        check("full_ready", 32'(bus4.data_ready), 32'(0));
        @(negedge clk);
        bus4.data_in    = 8'h06;
        bus4.data_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (cnt4 != 3'd4) break;
        end
        bus4.data_valid = 1'b0;
        check("full_pop_edge_count", 32'(cnt4), 32'(3));
        check("full_pop_edge_ready", 32'(bus4.data_ready), 32'(1));
        wait_idle4("full_drain");
        check("full_sb_empty", 32'(sb4.size()), 32'(0));

        // Reset during DATA bit 3 of 0x3C with two bytes queued
        drive4(8'h3C);
        drive4(8'h11);
        drive4(8'h22);
        repeat (16) @(posedge clk);
        #2;
        check("midrst_queued", 32'(cnt4), 32'(2));
        check("midrst_in_frame", 32'(busy4), 32'(1));
        reset = 1'b1;
        #1;
        check("midrst_tx", 32'(tx4), 32'(1));
        check("midrst_count", 32'(cnt4), 32'(0));
        check("midrst_busy", 32'(busy4), 32'(0));
        sb4.delete();
        k = starts4.size();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (busy4 || tx4 !== 1'b1) n++;
        end
        check("midrst_quiet", 32'(n), 32'(0));
        check("midrst_no_frames", 32'(starts4.size() - k), 32'(0));

        // Minimum divisor: 0x80 at 2 clocks per bit, 20-cycle frame
        exp_byte = 8'h80;
        for (int j = 0; j < 20; j++) begin
            if (j / 2 == 0)      wave_exp[j] = 1'b0;
            else if (j / 2 == 9) wave_exp[j] = 1'b1;
            else                 wave_exp[j] = exp_byte[j/2 - 1];
        end
        drive2(exp_byte);
        busy_ok = 1'b1;
        for (int j = 0; j < 20; j++) begin
            @(posedge clk);
            #1;
            wave[j] = tx2;
            if (!busy2) busy_ok = 1'b0;
        end
        check("min_div_wave", 32'(wave), 32'(wave_exp));
        check("min_div_busy_high", 32'(busy_ok), 32'(1));
        @(posedge clk);
        #1;
        check("min_div_busy_fall", 32'(busy2), 32'(0));
        repeat (2) @(negedge clk);
        check("min_div_sb_empty", 32'(sb2.size()), 32'(0));

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
